inst_fetch_pair: RTL and testbench

//  Fetch front end that writes the instruction buffer. Generates the fetch PC and runs a
//  one-outstanding ICache request/response handshake. Each response is pushed into the buffer
//  as an instruction pair, or as a single instruction for an unaligned PC or a delay slot.

---
 rtl/inst_fetch_pair.sv | 201 ++++++++++++++++++++
 tb/tb_inst_fetch_pair.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_pair.sv
// inst_fetch_pair: fetch front end feeding the instruction buffer.
// Generates the fetch PC, runs a single-outstanding ICache request/response
// handshake and pushes each response as an instruction pair or, for an
// unaligned PC or a delay slot, as a single instruction. Handles branch
// redirect (with pending delay slot), exception flush and buffer backpressure.
// Optional feature: define FETCH_STALL_CNT_EN to build a saturating counter of
// cycles spent waiting to request while the buffer is full.
module inst_fetch_pair #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic [31:0]      flush_pc_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  input  logic             redirect_ds_i,
  input  logic [31:0]      redirect_ds_pc_i,
  input  logic             buffer_full_i,
  output logic             icache_req_o,
  output logic [31:0]      icache_addr_o,
  input  logic             icache_addr_ok_i,
  input  logic             icache_data_ok_i,
  input  logic [63:0]      icache_rdata_i,
  output logic [31:0]      fetch_inst1_o,
  output logic [31:0]      fetch_inst2_o,
  output logic [31:0]      fetch_inst1_addr_o,
  output logic [31:0]      fetch_inst2_addr_o,
  output logic             fetch_inst1_valid_o,
  output logic             fetch_inst2_valid_o,
  output logic             fetch_single_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] target_q, target_d;
  logic        ds_fetch_q, ds_fetch_d;
  logic        req_single_q, req_single_d;
  logic        req_ds_q, req_ds_d;
  logic [31:0] inst1_q, inst1_d, inst2_q, inst2_d;
  logic [31:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic        valid1_q, valid1_d, valid2_q, valid2_d;
  logic        single_q, single_d;
  logic        req_fire;

  // A request is offered only in REQ and only while the buffer has room.
  assign icache_req_o  = (state_q == S_REQ) && !buffer_full_i && !rst;
  assign icache_addr_o = {pc_q[31:3], 3'b000};
  assign req_fire      = icache_req_o && icache_addr_ok_i;

  // Next-state, PC and push formation; flush/redirect override the normal path.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a value unassigned and infers a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    target_d     = target_q;
    ds_fetch_d   = ds_fetch_q;
    req_single_d = req_single_q;
    req_ds_d     = req_ds_q;
    inst1_d      = inst1_q;
    inst2_d      = inst2_q;
    addr1_d      = addr1_q;
    addr2_d      = addr2_q;
    valid1_d     = 1'b0;
    valid2_d     = 1'b0;
    single_d     = 1'b0;

    unique case (state_q)
      S_REQ: begin
        if (req_fire) begin
          req_pc_d     = pc_q;
          req_single_d = pc_q[2] | ds_fetch_q;
          req_ds_d     = ds_fetch_q;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (icache_data_ok_i) begin
          // The word at req_pc sits in the upper half when req_pc[2] is set.
          inst1_d  = req_pc_q[2] ? icache_rdata_i[63:32] : icache_rdata_i[31:0];
          inst2_d  = icache_rdata_i[63:32];
          addr1_d  = req_pc_q;
          addr2_d  = req_pc_q + 32'd4;
          valid1_d = 1'b1;
          valid2_d = !req_single_q;
          single_d = req_single_q;
          if (req_ds_q) begin
            pc_d       = target_q;
            ds_fetch_d = 1'b0;
          end else if (req_single_q) begin
            pc_d = req_pc_q + 32'd4;
          end else begin
            pc_d = req_pc_q + 32'd8;
          end
          state_d = S_REQ;
        end
      end
      S_DISCARD: begin
        if (icache_data_ok_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (flush_i || redirect_i) begin
      valid1_d = 1'b0;
      valid2_d = 1'b0;
      single_d = 1'b0;
      if (flush_i) begin
        pc_d       = flush_pc_i;
        ds_fetch_d = 1'b0;
      end else if (redirect_ds_i) begin
        pc_d       = redirect_ds_pc_i;
        target_d   = redirect_pc_i;
        ds_fetch_d = 1'b1;
      end else begin
        pc_d       = redirect_pc_i;
        ds_fetch_d = 1'b0;
      end
      // A response still owed by the cache must be swallowed before refetching.
      if (((state_q == S_WAIT || state_q == S_DISCARD) && !icache_data_ok_i) ||
          (state_q == S_REQ && req_fire)) begin
        state_d = S_DISCARD;
      end else begin
        state_d = S_REQ;
      end
    end
  end

  // State, PC and push registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      target_q     <= '0;
      ds_fetch_q   <= 1'b0;
      req_single_q <= 1'b0;
      req_ds_q     <= 1'b0;
      inst1_q      <= '0;
      inst2_q      <= '0;
      addr1_q      <= '0;
      addr2_q      <= '0;
      valid1_q     <= 1'b0;
      valid2_q     <= 1'b0;
      single_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      target_q     <= target_d;
      ds_fetch_q   <= ds_fetch_d;
      req_single_q <= req_single_d;
      req_ds_q     <= req_ds_d;
      inst1_q      <= inst1_d;
      inst2_q      <= inst2_d;
      addr1_q      <= addr1_d;
      addr2_q      <= addr2_d;
      valid1_q     <= valid1_d;
      valid2_q     <= valid2_d;
      single_q     <= single_d;
    end
  end

  assign fetch_inst1_o       = inst1_q;
  assign fetch_inst2_o       = inst2_q;
  assign fetch_inst1_addr_o  = addr1_q;
  assign fetch_inst2_addr_o  = addr2_q;
  assign fetch_inst1_valid_o = valid1_q;
  assign fetch_inst2_valid_o = valid2_q;
  assign fetch_single_o      = single_q;

`ifdef FETCH_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles held in REQ by a full buffer.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_REQ && buffer_full_i && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_pair.sv
// Testbench for inst_fetch_pair: directed stimulus, a small ICache model with
// programmable latency, and a scoreboard of expected pushes checked by a monitor.
module tb_inst_fetch_pair;

  logic        clk, rst;
  logic        flush_i, redirect_i, redirect_ds_i, buffer_full_i;
  logic [31:0] flush_pc_i, redirect_pc_i, redirect_ds_pc_i;
  logic        icache_req_o, icache_addr_ok_i, icache_data_ok_i;
  logic [31:0] icache_addr_o;
  logic [63:0] icache_rdata_i;
  logic [31:0] fetch_inst1_o, fetch_inst2_o, fetch_inst1_addr_o, fetch_inst2_addr_o;
  logic        fetch_inst1_valid_o, fetch_inst2_valid_o, fetch_single_o;
  logic [31:0] stall_cnt_o;

  inst_fetch_pair dut (
    .clk(clk), .rst(rst),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .redirect_ds_i(redirect_ds_i), .redirect_ds_pc_i(redirect_ds_pc_i),
    .buffer_full_i(buffer_full_i),
    .icache_req_o(icache_req_o), .icache_addr_o(icache_addr_o),
    .icache_addr_ok_i(icache_addr_ok_i), .icache_data_ok_i(icache_data_ok_i),
    .icache_rdata_i(icache_rdata_i),
    .fetch_inst1_o(fetch_inst1_o), .fetch_inst2_o(fetch_inst2_o),
    .fetch_inst1_addr_o(fetch_inst1_addr_o), .fetch_inst2_addr_o(fetch_inst2_addr_o),
    .fetch_inst1_valid_o(fetch_inst1_valid_o), .fetch_inst2_valid_o(fetch_inst2_valid_o),
    .fetch_single_o(fetch_single_o),
    .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] i1, a1, i2, a2;
    logic        v2, s;
  } push_t;

  push_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    lat   = 1;

  // Instruction memory contents: each word is its address with a fixed tag.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic push_t mk_pair(input logic [31:0] a);
    push_t p;
    p.i1 = mem(a);  p.a1 = a;
    p.i2 = mem(a + 32'd4);  p.a2 = a + 32'd4;
    p.v2 = 1'b1;  p.s = 1'b0;
    return p;
  endfunction

  function automatic push_t mk_single(input logic [31:0] a);
    push_t p;
    p.i1 = mem(a);  p.a1 = a;
    p.i2 = '0;  p.a2 = '0;
    p.v2 = 1'b0;  p.s = 1'b1;
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ICache model: accepts every request at once, answers after lat cycles, forgets on rst.
  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] pa;
    pend = 1'b0; cnt = 0; pa = '0;
    icache_addr_ok_i = 1'b1;
    icache_data_ok_i = 1'b0;
    icache_rdata_i   = '0;
    forever begin
      @(negedge clk); #1;
      icache_data_ok_i = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (cnt == 0) begin
            icache_data_ok_i = 1'b1;
            icache_rdata_i   = {mem(pa + 32'd4), mem(pa)};
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (icache_req_o && icache_addr_ok_i) begin
          pend = 1'b1;
          pa   = icache_addr_o;
          cnt  = lat - 1;
        end
      end
    end
  end

  // Monitor: every push the DUT presents must match the head of the scoreboard.
  initial begin
    push_t e;
    forever begin
      @(negedge clk);
      if (!rst && (fetch_inst1_valid_o || fetch_inst2_valid_o || fetch_single_o)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_push: got addr %h v1=%b v2=%b single=%b, expected none",
                   fetch_inst1_addr_o, fetch_inst1_valid_o, fetch_inst2_valid_o, fetch_single_o);
        end else begin
          e = exp_q.pop_front();
          check("inst1_valid", 32'(fetch_inst1_valid_o), 32'd1);
          check("inst1", fetch_inst1_o, e.i1);
          check("inst1_addr", fetch_inst1_addr_o, e.a1);
          check("inst2_valid", 32'(fetch_inst2_valid_o), 32'(e.v2));
          check("single", 32'(fetch_single_o), 32'(e.s));
          if (e.v2) begin
            check("inst2", fetch_inst2_o, e.i2);
            check("inst2_addr", fetch_inst2_addr_o, e.a2);
          end
        end
      end
    end
  end

  // One request window: the buffer opens for exactly one cycle, then the response drains.
  task automatic fetch_one(input logic [31:0] exp_addr);
    @(negedge clk);
    buffer_full_i = 1'b0;
    #1;
    check("req_valid", 32'(icache_req_o), 32'd1);
    check("req_addr", icache_addr_o, exp_addr);
    @(negedge clk);
    buffer_full_i = 1'b1;
    repeat (lat + 3) @(negedge clk);
  endtask

  task automatic redirect(input logic ds, input logic [31:0] tgt, input logic [31:0] ds_pc);
    redirect_i = 1'b1; redirect_ds_i = ds;
    redirect_pc_i = tgt; redirect_ds_pc_i = ds_pc;
    @(negedge clk);
    redirect_i = 1'b0; redirect_ds_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c0;
    flush_i = 1'b0; redirect_i = 1'b0; redirect_ds_i = 1'b0;
    flush_pc_i = '0; redirect_pc_i = '0; redirect_ds_pc_i = '0;
    buffer_full_i = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    // Reset state.
    check("rst_req", 32'(icache_req_o), 32'd0);
    check("rst_v1", 32'(fetch_inst1_valid_o), 32'd0);
    check("rst_v2", 32'(fetch_inst2_valid_o), 32'd0);
    check("rst_single", 32'(fetch_single_o), 32'd0);
    check("rst_stall", stall_cnt_o, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Sequential pairs from the reset PC.
    exp_q.push_back(mk_pair(32'hBFC0_0000));
    fetch_one(32'hBFC0_0000);
    exp_q.push_back(mk_pair(32'hBFC0_0008));
    fetch_one(32'hBFC0_0008);

    // Backpressure: no requests, stall counter advances by one per cycle.
    c0 = stall_cnt_o;
    for (int i = 0; i < 10; i++) begin
      #1 check("full_req", 32'(icache_req_o), 32'd0);
      @(negedge clk);
    end
`ifdef FETCH_STALL_CNT_EN
    check("stall_cnt_delta", stall_cnt_o, c0 + 32'd10);
`else
    check("stall_cnt_zero", stall_cnt_o, 32'd0);
`endif

    // Redirect to an unaligned target: single from the upper half, then a pair.
    redirect(1'b0, 32'h8000_0104, 32'h0);
    exp_q.push_back(mk_single(32'h8000_0104));
    fetch_one(32'h8000_0100);
    exp_q.push_back(mk_pair(32'h8000_0108));
    fetch_one(32'h8000_0108);

    // Redirect with pending delay slot while waiting: stale data dropped.
    lat = 3;
    @(negedge clk);
    buffer_full_i = 1'b0;
    @(negedge clk);
    buffer_full_i = 1'b1;
    redirect(1'b1, 32'h8000_0200, 32'h8000_0010);
    repeat (5) @(negedge clk);
    lat = 1;
    exp_q.push_back(mk_single(32'h8000_0010));
    fetch_one(32'h8000_0010);
    exp_q.push_back(mk_pair(32'h8000_0200));
    fetch_one(32'h8000_0200);

    // PC wraps past the top of the address space.
    redirect(1'b0, 32'hFFFF_FFF8, 32'h0);
    exp_q.push_back(mk_pair(32'hFFFF_FFF8));
    fetch_one(32'hFFFF_FFF8);
    exp_q.push_back(mk_pair(32'h0000_0000));
    fetch_one(32'h0000_0000);

    // Flush and redirect together with data_ok: no push, flush wins, delay slot cleared.
    @(negedge clk);
    buffer_full_i = 1'b0;
    @(negedge clk);
    buffer_full_i = 1'b1;
    flush_i = 1'b1; flush_pc_i = 32'hBFC0_0380;
    redirect_i = 1'b1; redirect_ds_i = 1'b1;
    redirect_pc_i = 32'h8000_0300; redirect_ds_pc_i = 32'h8000_0040;
    @(negedge clk);
    flush_i = 1'b0; redirect_i = 1'b0; redirect_ds_i = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(mk_pair(32'hBFC0_0380));
    fetch_one(32'hBFC0_0380);

    // Async reset in the middle of a transaction.
    lat = 3;
    @(negedge clk);
    buffer_full_i = 1'b0;
    @(negedge clk);
    buffer_full_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_req", 32'(icache_req_o), 32'd0);
    check("midrst_v1", 32'(fetch_inst1_valid_o), 32'd0);
    check("midrst_single", 32'(fetch_single_o), 32'd0);
    check("midrst_stall", stall_cnt_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    lat = 1;
    exp_q.push_back(mk_pair(32'hBFC0_0000));
    fetch_one(32'hBFC0_0000);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
